// File: rtl/decoded_instr_queue.sv
// Decoded-instruction queue between the ID stage and the issue stage.
// Small first-word-fall-through FIFO with a limit on in-flight
// (accepted but unresolved) control-flow instructions.

package decoded_instr_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } scoreboard_entry_t;

endpackage

module decoded_instr_queue
  import decoded_instr_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int MAX_CF = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int CF_W  = $clog2(MAX_CF + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  scoreboard_entry_t decoded_instr_i,
  input  logic              is_control_flow_instr_i,
  input  logic              decoded_valid_i,
  output logic              decoded_ack_o,
  output scoreboard_entry_t issue_instr_o,
  output logic              issue_is_cf_o,
  output logic              issue_valid_o,
  input  logic              issue_ack_i,
  input  logic              cf_resolved_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [CF_W-1:0]   cf_pending_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CF_W-1:0]  CF_LIMIT = CF_W'(MAX_CF);

  scoreboard_entry_t mem_q    [DEPTH];
  logic              mem_cf_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CF_W-1:0]  cf_pending_q;

  logic             push, pop;
  logic             cf_push, cf_res;
  logic [PTR_W-1:0] head_idx;

  // Handshake and pointer-advance decisions; flush kills both sides at once.
  always_comb begin
    decoded_ack_o = !flush_i && (count_q != FULL_CNT) &&
                    !(is_control_flow_instr_i && (cf_pending_q == CF_LIMIT));
    issue_valid_o = (count_q != '0) && !flush_i;
    push          = decoded_valid_i && decoded_ack_o;
    pop           = issue_valid_o && issue_ack_i;
    cf_push       = push && is_control_flow_instr_i;
    // Resolution with nothing outstanding saturates at zero.
    cf_res        = cf_resolved_i && !flush_i && (cf_pending_q != '0);
  end

  // Head selection: when empty, keep showing the slot that was read last so
  // the outputs do not change just because the queue drained.
  always_comb begin
    head_idx      = (count_q == '0) ? (rd_ptr_q - PTR_W'(1)) : rd_ptr_q;
    issue_instr_o = mem_q[head_idx];
    issue_is_cf_o = mem_cf_q[head_idx];
  end

  // Storage writes at the write pointer; cleared on reset only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i]    <= '0;
        mem_cf_q[i] <= 1'b0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q]    <= decoded_instr_i;
      mem_cf_q[wr_ptr_q] <= is_control_flow_instr_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Outstanding control-flow count; includes entries already handed to issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cf_pending_q <= '0;
    end else if (flush_i) begin
      cf_pending_q <= '0;
    end else begin
      case ({cf_push, cf_res})
        2'b10:   cf_pending_q <= cf_pending_q + CF_W'(1);
        2'b01:   cf_pending_q <= cf_pending_q - CF_W'(1);
        default: cf_pending_q <= cf_pending_q;
      endcase
    end
  end

  assign count_o      = count_q;
  assign cf_pending_o = cf_pending_q;

  // A resolution with no outstanding control-flow instruction means the
  // branch unit and this queue disagree about what is in flight.
  cf_underflow_chk : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(cf_resolved_i && !flush_i && (cf_pending_q == '0))
  );

endmodule

// File: tb/tb_decoded_instr_queue.sv
// Self-checking bench for decoded_instr_queue (DEPTH=4, MAX_CF=2).
// Per-cycle vector table with expected handshake/occupancy values, plus a
// scoreboard of accepted instructions compared against the head on issue.

module tb_decoded_instr_queue;
  import decoded_instr_queue_pkg::*;

  localparam int DEPTH  = 4;
  localparam int MAX_CF = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  scoreboard_entry_t decoded_instr_i;
  logic              is_control_flow_instr_i;
  logic              decoded_valid_i;
  logic              decoded_ack_o;
  scoreboard_entry_t issue_instr_o;
  logic              issue_is_cf_o;
  logic              issue_valid_o;
  logic              issue_ack_i;
  logic              cf_resolved_i;
  logic [2:0]        count_o;
  logic [1:0]        cf_pending_o;

  decoded_instr_queue #(.DEPTH(DEPTH), .MAX_CF(MAX_CF)) dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .flush_i                 (flush_i),
    .decoded_instr_i         (decoded_instr_i),
    .is_control_flow_instr_i (is_control_flow_instr_i),
    .decoded_valid_i         (decoded_valid_i),
    .decoded_ack_o           (decoded_ack_o),
    .issue_instr_o           (issue_instr_o),
    .issue_is_cf_o           (issue_is_cf_o),
    .issue_valid_o           (issue_valid_o),
    .issue_ack_i             (issue_ack_i),
    .cf_resolved_i           (cf_resolved_i),
    .count_o                 (count_o),
    .cf_pending_o            (cf_pending_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic        cf;
  } sb_t;
  sb_t sb[$];

  // Inputs for one cycle and the outputs expected before that cycle's edge.
  typedef struct {
    logic        vld;
    logic        cf;
    logic [31:0] pc;
    logic        iack;
    logic        res;
    logic        flush;
    logic        e_ack;
    logic        e_valid;
    logic [2:0]  e_cnt;
    logic [1:0]  e_cf;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic cf, input logic [31:0] pc,
                              input logic iack, input logic res, input logic flush,
                              input logic e_ack, input logic e_valid,
                              input logic [2:0] e_cnt, input logic [1:0] e_cf);
    vec_t v;
    v.vld = vld; v.cf = cf; v.pc = pc; v.iack = iack; v.res = res; v.flush = flush;
    v.e_ack = e_ack; v.e_valid = e_valid; v.e_cnt = e_cnt; v.e_cf = e_cf;
    return v;
  endfunction

  task automatic apply_vec(input int idx, input vec_t v);
    sb_t exp_head;
    @(negedge clk_i);
    decoded_valid_i         = v.vld;
    is_control_flow_instr_i = v.cf;
    decoded_instr_i         = '0;
    decoded_instr_i.pc      = v.pc;
    decoded_instr_i.op      = v.pc[9:2];
    issue_ack_i             = v.iack;
    cf_resolved_i           = v.res;
    flush_i                 = v.flush;
    #1;
    check($sformatf("v%0d ack", idx),   32'(decoded_ack_o), 32'(v.e_ack));
    check($sformatf("v%0d valid", idx), 32'(issue_valid_o), 32'(v.e_valid));
    check($sformatf("v%0d count", idx), 32'(count_o),       32'(v.e_cnt));
    check($sformatf("v%0d cf_pend", idx), 32'(cf_pending_o), 32'(v.e_cf));
    if (v.e_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL v%0d head: got pc %h expected no entry", idx, issue_instr_o.pc);
      end else begin
        exp_head = sb[0];
        check($sformatf("v%0d head_pc", idx), issue_instr_o.pc, exp_head.pc);
        check($sformatf("v%0d head_cf", idx), 32'(issue_is_cf_o), 32'(exp_head.cf));
        if (v.iack) void'(sb.pop_front());
      end
    end
    if (v.vld && v.e_ack) sb.push_back('{pc: v.pc, cf: v.cf});
    if (v.flush) sb.delete();
  endtask

  initial begin
    rst_ni                  = 1'b0;
    flush_i                 = 1'b0;
    decoded_instr_i         = '0;
    is_control_flow_instr_i = 1'b0;
    decoded_valid_i         = 1'b0;
    issue_ack_i             = 1'b0;
    cf_resolved_i           = 1'b0;

    //            vld cf  pc            iack res fl  ack val cnt cf
    // three pushes, head visible one cycle after the first
    vecs.push_back(mk(1, 0, 32'h8000_0000, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h8000_0004, 0, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 32'h8000_0008, 0, 0, 0, 1, 1, 2, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 1, 3, 0));
    // fill, full with and without pop, accept after pop, wrap and drain
    vecs.push_back(mk(1, 0, 32'h8000_000C, 0, 0, 0, 1, 1, 3, 0));
    vecs.push_back(mk(1, 0, 32'h8000_0010, 0, 0, 0, 0, 1, 4, 0));
    vecs.push_back(mk(1, 0, 32'h8000_0010, 1, 0, 0, 0, 1, 4, 0));
    vecs.push_back(mk(1, 0, 32'h8000_0010, 0, 0, 0, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 0, 1, 4, 0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 1, 3, 0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 1, 2, 0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 0, 0, 0));
    // CF limit: third branch blocked until a resolution
    vecs.push_back(mk(1, 1, 32'h9000_0000, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'h9000_0004, 0, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 1, 32'h9000_0008, 0, 0, 0, 0, 1, 2, 2));
    vecs.push_back(mk(1, 1, 32'h9000_0008, 0, 1, 0, 0, 1, 2, 2));
    vecs.push_back(mk(1, 1, 32'h9000_0008, 0, 0, 0, 1, 1, 2, 1));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 1, 3, 2));
    // non-CF accepted at the CF limit
    vecs.push_back(mk(1, 0, 32'h9000_000C, 0, 0, 0, 1, 1, 3, 2));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 0, 1, 4, 2));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 1, 3, 2));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 1, 2, 2));
    vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, 1, 1, 1, 2));
    // issued branches stay pending until resolved
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, 1, 0, 0, 1));
    // CF push together with a resolution leaves the count unchanged
    vecs.push_back(mk(1, 1, 32'hA000_0000, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'hA000_0004, 0, 1, 0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 1, 2, 1));
    // build 3 entries / 2 pending, then flush with valid and issue ack high
    vecs.push_back(mk(1, 0, 32'hA000_0008, 0, 0, 0, 1, 1, 2, 1));
    vecs.push_back(mk(1, 1, 32'hA000_000C, 1, 0, 0, 1, 1, 3, 1));
    vecs.push_back(mk(1, 0, 32'hB000_0000, 1, 1, 1, 0, 0, 3, 2));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 0, 0, 0));
    // two entries queued ahead of the reset check
    vecs.push_back(mk(1, 0, 32'hC000_0000, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 32'hC000_0004, 0, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, 1, 1, 2, 1));

    // reset state
    #12;
    check("rst valid",   32'(issue_valid_o), 32'd0);
    check("rst is_cf",   32'(issue_is_cf_o), 32'd0);
    check("rst instr",   issue_instr_o.pc,   32'd0);
    check("rst ack",     32'(decoded_ack_o), 32'd1);
    check("rst count",   32'(count_o),       32'd0);
    check("rst cf_pend", 32'(cf_pending_o),  32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // asynchronous reset mid-operation: cleared without waiting for an edge
    @(negedge clk_i);
    decoded_valid_i = 1'b0;
    issue_ack_i     = 1'b0;
    cf_resolved_i   = 1'b0;
    flush_i         = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst valid",   32'(issue_valid_o), 32'd0);
    check("midrst count",   32'(count_o),       32'd0);
    check("midrst cf_pend", 32'(cf_pending_o),  32'd0);
    check("midrst ack",     32'(decoded_ack_o), 32'd1);
    sb.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // queue must work normally after the reset
    apply_vec(100, mk(1, 0, 32'hD000_0000, 0, 0, 0, 1, 0, 0, 0));
    apply_vec(101, mk(0, 0, 32'h0,         1, 0, 0, 1, 1, 1, 0));
    apply_vec(102, mk(0, 0, 32'h0,         0, 0, 0, 1, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
